// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared state type and frame constants for the LIS3DH SPI master.
// Revision : 1.0
// ============================================================================
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEAD  = 3'd1,
      LOW   = 3'd2,
      HIGH  = 3'd3,
      TRAIL = 3'd4,
      DONE  = 3'd5
   } spi_state_t;

   localparam int CMD_RW_BIT  = 23;
   localparam int CMD_MS_BIT  = 22;
   localparam int FRAME_SHORT = 16;
   localparam int FRAME_LONG  = 24;

   // Index of the final bit of a frame, as seen by a zero-based bit counter.
   function automatic logic [4:0] last_bit_idx(input logic is_long);
      return is_long ? 5'(FRAME_LONG - 1) : 5'(FRAME_SHORT - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module   : spi_clk_div
// Purpose  : Counts SPC_HALF clk cycles per phase and pulses o_tick on the last.
// Revision : 1.0
// ============================================================================
module spi_clk_div #(
   parameter int SPC_HALF = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   output logic o_tick
);

   localparam int            CW   = (SPC_HALF > 1) ? $clog2(SPC_HALF) : 1;
   localparam logic [CW-1:0] LAST = CW'(SPC_HALF - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // The counter restarts on every tick so each phase is exactly SPC_HALF long.
   always_comb begin
      o_tick = i_en && (cnt_q == LAST);
      cnt_d  = cnt_q;
      if (!i_en || o_tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : Mode-3 SPI master for the LIS3DH, 16/24-bit frames; optional
//            busy output when SPI_BUSY_EN is defined.
// Revision : 1.0
// ============================================================================
module spi_master
   import spi_pkg::*;
#(
   parameter int SPC_HALF = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] data_tx,
   input  logic        data_tx_valid,
   output logic        done,
   output logic [15:0] data_rx,
   input  logic        sdo,
   output logic        cs,
   output logic        spc,
   output logic        sdi
`ifdef SPI_BUSY_EN
   ,
   output logic        busy
`endif
);

   spi_state_t  state_q, state_d;
   logic [23:0] shift_q, shift_d;
   logic [15:0] rx_q, rx_d;
   logic [15:0] data_rx_q, data_rx_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic        long_q, long_d;
   logic        cs_q, cs_d;
   logic        spc_q, spc_d;
   logic        sdi_q, sdi_d;
   logic        done_q, done_d;
   logic        div_en;
   logic        tick;

   assign div_en = state_q inside {LEAD, LOW, HIGH, TRAIL};

   spi_clk_div #(
      .SPC_HALF (SPC_HALF)
   ) u_clk_div (
      .clk    (clk),
      .reset  (reset),
      .i_en   (div_en),
      .o_tick (tick)
   );

   // Pin outputs are registered from next-state values so they never glitch.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      rx_d      = rx_q;
      data_rx_d = data_rx_q;
      bit_cnt_d = bit_cnt_q;
      long_d    = long_q;
      cs_d      = cs_q;
      spc_d     = spc_q;
      sdi_d     = sdi_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (data_tx_valid) begin
               state_d   = LEAD;
               shift_d   = data_tx;
               long_d    = data_tx[CMD_MS_BIT];
               bit_cnt_d = '0;
               cs_d      = 1'b0;
               spc_d     = 1'b1;
               sdi_d     = data_tx[CMD_RW_BIT];
            end
         end
         LEAD: begin
            if (tick) begin
               state_d = LOW;
               spc_d   = 1'b0;
            end
         end
         LOW: begin
            if (tick) begin
               state_d = HIGH;
               spc_d   = 1'b1;
               rx_d    = {rx_q[14:0], sdo};
            end
         end
         HIGH: begin
            if (tick) begin
               if (bit_cnt_q == last_bit_idx(long_q)) begin
                  state_d = TRAIL;
               end else begin
                  state_d   = LOW;
                  spc_d     = 1'b0;
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  shift_d   = {shift_q[22:0], 1'b0};
                  sdi_d     = shift_q[22];
               end
            end
         end
         TRAIL: begin
            if (tick) begin
               state_d   = DONE;
               cs_d      = 1'b1;
               sdi_d     = 1'b1;
               done_d    = 1'b1;
               // Short frames only carry one data byte; the command-phase bits are dropped.
               data_rx_d = long_q ? rx_q : {8'h00, rx_q[7:0]};
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cs_d    = 1'b1;
            spc_d   = 1'b1;
            sdi_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         rx_q      <= '0;
         data_rx_q <= '0;
         bit_cnt_q <= '0;
         long_q    <= 1'b0;
         cs_q      <= 1'b1;
         spc_q     <= 1'b1;
         sdi_q     <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         rx_q      <= rx_d;
         data_rx_q <= data_rx_d;
         bit_cnt_q <= bit_cnt_d;
         long_q    <= long_d;
         cs_q      <= cs_d;
         spc_q     <= spc_d;
         sdi_q     <= sdi_d;
         done_q    <= done_d;
      end
   end

   assign cs      = cs_q;
   assign spc     = spc_q;
   assign sdi     = sdi_q;
   assign done    = done_q;
   assign data_rx = data_rx_q;

`ifdef SPI_BUSY_EN
   logic busy_q, busy_d;

   always_comb begin
      busy_d = state_d inside {LEAD, LOW, HIGH, TRAIL};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Purpose  : Directed, table-driven bench for spi_master with SPC_HALF=2.
// Revision : 1.0
// ============================================================================
module tb_spi_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] data_tx = '0;
   logic        data_tx_valid = 1'b0;
   logic        done;
   logic [15:0] data_rx;
   logic        sdo = 1'b1;
   logic        cs;
   logic        spc;
   logic        sdi;

   int total = 0;
   int bad   = 0;

   // Bus monitor / sensor model state.
   int          mon_rises = 0;
   int          mon_cslow = 0;
   int          mon_dones = 0;
   int          mon_viol  = 0;
   logic [23:0] mon_sdi   = '0;
   int          fr_base   = 0;
   int          fr_n      = 16;
   logic [15:0] fr_resp   = '0;

   typedef struct {
      logic [23:0] tx;
      logic [15:0] resp;
      int          edges;
      int          cs_low;
      logic [23:0] sdi_bits;
      logic [15:0] rx;
   } vec_t;

   vec_t vecs[5];

   spi_master #(
      .SPC_HALF (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .data_tx       (data_tx),
      .data_tx_valid (data_tx_valid),
      .done          (done),
      .data_rx       (data_rx),
      .sdo           (sdo),
      .cs            (cs),
      .spc           (spc),
      .sdi           (sdi)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   // Monitor sampled on the falling clk edge; also acts as the sensor driving sdo.
   initial begin
      logic prev_spc, prev_cs, prev_sdi;
      int   k;
      prev_spc = 1'b1;
      prev_cs  = 1'b1;
      prev_sdi = 1'b1;
      forever begin
         @(negedge clk);
         if (spc && !prev_spc) begin
            mon_rises = mon_rises + 1;
            mon_sdi   = {mon_sdi[22:0], sdi};
         end
         if (!spc && prev_spc) begin
            k = mon_rises - fr_base + 1;
            sdo = (k > 8 && k <= fr_n) ? fr_resp[fr_n - k] : 1'b1;
         end
         if (!cs) mon_cslow = mon_cslow + 1;
         if (done) mon_dones = mon_dones + 1;
         if (!cs && !prev_cs && spc && prev_spc && (sdi !== prev_sdi)) mon_viol = mon_viol + 1;
         prev_spc = spc;
         prev_cs  = cs;
         prev_sdi = sdi;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_xfer(input vec_t v, input bit extra_valid);
      int          r0, c0, d0, v0;
      bit          got;
      logic [23:0] mask;
      @(negedge clk);
      fr_n    = v.tx[22] ? 24 : 16;
      fr_resp = v.resp;
      fr_base = mon_rises;
      r0 = mon_rises;
      c0 = mon_cslow;
      d0 = mon_dones;
      v0 = mon_viol;
      mask = v.tx[22] ? 24'hFFFFFF : 24'h00FFFF;
      data_tx       = v.tx;
      data_tx_valid = 1'b1;
      @(negedge clk);
      data_tx_valid = 1'b0;
      data_tx       = 24'hFFFFFF;
      check("cs_fall", {31'd0, cs}, 32'd0);
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         if (extra_valid) data_tx_valid = ((i % 7) == 3);
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            check("data_rx", {16'd0, data_rx}, {16'd0, v.rx});
         end
      end
      data_tx_valid = 1'b0;
      check("done_seen", {31'd0, got}, 32'd1);
      @(negedge clk);
      check("spc_edges", mon_rises - r0, v.edges);
      check("cs_low_cycles", mon_cslow - c0, v.cs_low);
      check("sdi_bits", {8'd0, mon_sdi & mask}, {8'd0, v.sdi_bits});
      check("done_pulses", mon_dones - d0, 1);
      check("sdi_stable_high", mon_viol - v0, 0);
      check("idle_cs", {31'd0, cs}, 32'd1);
      check("idle_spc", {31'd0, spc}, 32'd1);
      check("idle_sdi", {31'd0, sdi}, 32'd1);
   endtask

   initial begin
      int c0, d0;

      vecs[0] = '{tx: 24'h209700, resp: 16'h0000, edges: 16, cs_low: 68,  sdi_bits: 24'h002097, rx: 16'h0000};
      vecs[1] = '{tx: 24'hE8FFFF, resp: 16'hAAAA, edges: 24, cs_low: 100, sdi_bits: 24'hE8FFFF, rx: 16'hAAAA};
      vecs[2] = '{tx: 24'h8F0000, resp: 16'h0033, edges: 16, cs_low: 68,  sdi_bits: 24'h008F00, rx: 16'h0033};
      vecs[3] = '{tx: 24'h601234, resp: 16'h5A5A, edges: 24, cs_low: 100, sdi_bits: 24'h601234, rx: 16'h5A5A};
      vecs[4] = '{tx: 24'hBF0000, resp: 16'hFFC3, edges: 16, cs_low: 68,  sdi_bits: 24'h00BF00, rx: 16'h00C3};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_cs", {31'd0, cs}, 32'd1);
      check("rst_spc", {31'd0, spc}, 32'd1);
      check("rst_sdi", {31'd0, sdi}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_data_rx", {16'd0, data_rx}, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_xfer(vecs[i], 1'b0);
      end

      // Abort a single read partway through bit 10
      @(negedge clk);
      fr_n    = 16;
      fr_resp = 16'h0055;
      fr_base = mon_rises;
      data_tx = 24'h8F0000;
      data_tx_valid = 1'b1;
      @(negedge clk);
      data_tx_valid = 1'b0;
      for (int i = 0; i < 200 && (mon_rises - fr_base) < 10; i++) @(negedge clk);
      check("abort_reached_bit10", {31'd0, (mon_rises - fr_base) >= 10}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("abort_cs", {31'd0, cs}, 32'd1);
      check("abort_spc", {31'd0, spc}, 32'd1);
      check("abort_sdi", {31'd0, sdi}, 32'd1);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_data_rx", {16'd0, data_rx}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      run_xfer(vecs[0], 1'b0);

      // Extra start strobes during a transfer must be dropped, not queued
      run_xfer(vecs[2], 1'b1);
      c0 = mon_cslow;
      d0 = mon_dones;
      repeat (100) @(negedge clk);
      check("no_queued_cs", mon_cslow - c0, 0);
      check("no_queued_done", mon_dones - d0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
